// File: rtl/deep_pkg.sv
// Shared types for the weight-memory port arbiter.
// Used by the arbiter top and its selection logic.
package deep_pkg;

  localparam int ARB_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } arb_state_t;

  typedef enum logic {
    CLS_FP,
    CLS_BP
  } req_cls_t;

endpackage

// File: rtl/wt_arb_sel.sv
// Request selection for the weight port.
// Round-robin between classes, layer 0 first within a class.
module wt_arb_sel
  import deep_pkg::*;
(
  input  logic [1:0] fp_req,
  input  logic [1:0] bp_req,
  input  logic       prio_bp,
  output logic       any,
  output req_cls_t   cls,
  output logic       lyr
);

  logic fp_any;
  logic bp_any;
  logic pick_bp;

  always_comb begin
    fp_any  = |fp_req;
    bp_any  = |bp_req;
    any     = fp_any | bp_any;
    pick_bp = prio_bp ? bp_any : !fp_any;
    cls     = pick_bp ? CLS_BP : CLS_FP;
    lyr     = pick_bp ? !bp_req[0] : !fp_req[0];
  end

endmodule

// File: rtl/weight_port_arbiter.sv
// Serialises forward fetches and backprop updates onto the
// single weights port; pulses and acks are registered.
module weight_port_arbiter
  import deep_pkg::*;
#(
  parameter int LAT_RD = 2,
  parameter int LAT_WR = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] fp_req,
  input  logic [1:0] bp_req,
  output logic [1:0] fp_ack,
  output logic [1:0] bp_ack,
  output logic       mem_start0,
  output logic       mem_start1,
  output logic       mem_update0,
  output logic       mem_update1,
  output logic       busy,
  output logic       proto_err
);

  localparam logic [ARB_CNT_W-1:0] LAT_RD_C = ARB_CNT_W'(LAT_RD);
  localparam logic [ARB_CNT_W-1:0] LAT_WR_C = ARB_CNT_W'(LAT_WR);
  localparam logic [ARB_CNT_W-1:0] CNT_ONE  = ARB_CNT_W'(1);

  arb_state_t           state_q, state_d;
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 prio_q, prio_d;
  logic                 perr_q, perr_d;
  req_cls_t             cls_q, cls_d;
  logic                 lyr_q, lyr_d;
  logic [3:0]           mem_q, mem_d;
  logic [3:0]           ack_q, ack_d;

  logic       sel_any;
  req_cls_t   sel_cls;
  logic       sel_lyr;
  logic [1:0] sel_idx;
  logic [1:0] gnt_idx;
  logic [3:0] req_all;

  wt_arb_sel u_sel (
    .fp_req  (fp_req),
    .bp_req  (bp_req),
    .prio_bp (prio_q),
    .any     (sel_any),
    .cls     (sel_cls),
    .lyr     (sel_lyr)
  );

  // Index layout {class, layer} matches {update1,update0,start1,start0}
  assign req_all = {bp_req, fp_req};
  assign sel_idx = {sel_cls == CLS_BP, sel_lyr};
  assign gnt_idx = {cls_q == CLS_BP, lyr_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    perr_d  = perr_q;
    cls_d   = cls_q;
    lyr_d   = lyr_q;
    mem_d   = '0;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (sel_any) begin
          cls_d          = sel_cls;
          lyr_d          = sel_lyr;
          mem_d[sel_idx] = 1'b1;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = (cls_q == CLS_FP) ? LAT_RD_C : LAT_WR_C;
        perr_d  = perr_q | !req_all[gnt_idx];
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d  = cnt_q - 1'b1;
        perr_d = perr_q | !req_all[gnt_idx];
        if (cnt_q == CNT_ONE) begin
          ack_d[gnt_idx] = 1'b1;
          state_d        = ACK;
        end
      end
      ACK: begin
        prio_d  = (cls_q == CLS_FP);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      perr_q  <= 1'b0;
      cls_q   <= CLS_FP;
      lyr_q   <= 1'b0;
      mem_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      perr_q  <= perr_d;
      cls_q   <= cls_d;
      lyr_q   <= lyr_d;
      mem_q   <= mem_d;
      ack_q   <= ack_d;
    end
  end

  assign mem_start0  = mem_q[0];
  assign mem_start1  = mem_q[1];
  assign mem_update0 = mem_q[2];
  assign mem_update1 = mem_q[3];
  assign fp_ack      = ack_q[1:0];
  assign bp_ack      = ack_q[3:2];
  assign busy        = (state_q != IDLE);
  assign proto_err   = perr_q;

endmodule

// File: tb/tb_weight_port_arbiter.sv
// Scoreboard bench for weight_port_arbiter: a cycle-level
// reference model predicts pulses, acks, busy and proto_err.
module tb_weight_port_arbiter;

  localparam int LRD = 2;
  localparam int LWR = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] fp_req = '0;
  logic [1:0] bp_req = '0;
  logic [1:0] fp_ack, bp_ack;
  logic       ms0, ms1, mu0, mu1, busy, perr;

  logic [1:0] zero2 = '0;
  logic [1:0] sw1_req = '0;
  logic [1:0] sw15_req = '0;
  logic [1:0] s1_fa, s1_ba, s15_fa, s15_ba;
  logic       s1_ms0, s1_ms1, s1_mu0, s1_mu1, s1_busy, s1_perr;
  logic       s15_ms0, s15_ms1, s15_mu0, s15_mu1, s15_busy, s15_perr;

  weight_port_arbiter #(.LAT_RD(LRD), .LAT_WR(LWR)) u_dut (
    .clk(clk), .rst(rst), .fp_req(fp_req), .bp_req(bp_req),
    .fp_ack(fp_ack), .bp_ack(bp_ack),
    .mem_start0(ms0), .mem_start1(ms1),
    .mem_update0(mu0), .mem_update1(mu1),
    .busy(busy), .proto_err(perr)
  );

  weight_port_arbiter #(.LAT_RD(1), .LAT_WR(1)) u_l1 (
    .clk(clk), .rst(rst), .fp_req(sw1_req), .bp_req(zero2),
    .fp_ack(s1_fa), .bp_ack(s1_ba),
    .mem_start0(s1_ms0), .mem_start1(s1_ms1),
    .mem_update0(s1_mu0), .mem_update1(s1_mu1),
    .busy(s1_busy), .proto_err(s1_perr)
  );

  weight_port_arbiter #(.LAT_RD(15), .LAT_WR(1)) u_l15 (
    .clk(clk), .rst(rst), .fp_req(sw15_req), .bp_req(zero2),
    .fp_ack(s15_fa), .bp_ack(s15_ba),
    .mem_start0(s15_ms0), .mem_start1(s15_ms1),
    .mem_update0(s15_mu0), .mem_update1(s15_mu1),
    .busy(s15_busy), .proto_err(s15_perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         c;
    logic [3:0] code;
  } ev_t;

  ev_t        mem_q[$];
  ev_t        ack_q[$];
  logic [3:0] obs[$];
  logic [3:0] r = '0;
  int         drop_at[4];
  bit         rand_en = 0;
  bit         rec_en = 0;

  int free_at, lg, glat, gbit, perr_from;
  bit prio, granted;

  int n1 = 0, c1 = -1, n15 = 0, c15 = -1;

  function void chk(bit ok, string nm, int act, int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  task automatic apply_reset();
    mem_q.delete();
    ack_q.delete();
    free_at   = 0;
    lg        = -100;
    glat      = 0;
    gbit      = 0;
    prio      = 0;
    perr_from = 32'h7fffffff;
    for (int i = 0; i < 4; i++) drop_at[i] = -1;
    r = '0;
  endtask

  task automatic model_step();
    bit         fa, ba, pb;
    logic [1:0] src;
    int         lat;
    granted = 0;
    if (cyc >= lg + 1 && cyc <= lg + 1 + glat && !r[gbit] && perr_from > cyc + 1)
      perr_from = cyc + 1;
    if (cyc >= free_at && r != 0) begin
      fa   = |r[1:0];
      ba   = |r[3:2];
      pb   = prio ? ba : !fa;
      src  = pb ? r[3:2] : r[1:0];
      gbit = (pb ? 2 : 0) + (src[0] ? 0 : 1);
      lat  = pb ? LWR : LRD;
      mem_q.push_back('{cyc + 1, 4'(1 << gbit)});
      ack_q.push_back('{cyc + 2 + lat, 4'(1 << gbit)});
      free_at       = cyc + 3 + lat;
      lg            = cyc;
      glat          = lat;
      prio          = !pb;
      granted       = 1;
      drop_at[gbit] = cyc + 2 + lat;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (drop_at[i] == cyc) begin
        r[i] = 1'b0;
        drop_at[i] = -1;
      end
    if (rand_en)
      for (int i = 0; i < 4; i++)
        if (!r[i] && $urandom_range(0, 3) == 0) r[i] = 1'b1;
  endtask

  task automatic drive_model();
    fp_req = r[1:0];
    bp_req = r[3:2];
    if (rst) model_step();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      tick();
      drive_model();
    end
  endtask

  logic [3:0] cm, ca;
  ev_t        me;
  bit         expb;

  always @(negedge clk) begin
    cm = {mu1, mu0, ms1, ms0};
    ca = {bp_ack, fp_ack};
    if (cm != 0 || ca != 0)
      chk($countones({cm, ca}) == 1, "onehot", $countones({cm, ca}), 1);
    while (mem_q.size() > 0 && mem_q[0].c < cyc) begin
      chk(0, "mem_missing", -1, mem_q[0].c);
      void'(mem_q.pop_front());
    end
    while (ack_q.size() > 0 && ack_q[0].c < cyc) begin
      chk(0, "ack_missing", -1, ack_q[0].c);
      void'(ack_q.pop_front());
    end
    if (cm != 0) begin
      if (mem_q.size() == 0) chk(0, "mem_unexpected", int'(cm), 0);
      else begin
        me = mem_q.pop_front();
        chk(me.c == cyc, "mem_cycle", cyc, me.c);
        chk(me.code == cm, "mem_code", int'(cm), int'(me.code));
      end
      if (rec_en) obs.push_back(cm);
    end
    if (ca != 0) begin
      if (ack_q.size() == 0) chk(0, "ack_unexpected", int'(ca), 0);
      else begin
        me = ack_q.pop_front();
        chk(me.c == cyc, "ack_cycle", cyc, me.c);
        chk(me.code == ca, "ack_code", int'(ca), int'(me.code));
      end
    end
    expb = (cyc >= lg + 1) && (cyc <= lg + 2 + glat);
    chk(busy == expb, "busy", int'(busy), int'(expb));
    chk(perr == (cyc >= perr_from), "proto_err", int'(perr), int'(cyc >= perr_from));
    if (s1_fa != 0) begin
      n1++;
      c1 = cyc;
    end
    if (s15_fa != 0) begin
      n15++;
      c15 = cyc;
    end
  end

  int c0;
  logic [3:0] exp_ord [4];

  initial begin
    apply_reset();
    rst = 1'b0;
    repeat (6) begin
      tick();
      r = 4'($urandom);
      drive_model();
    end
    // Release with a single FP0 request
    tick();
    rst = 1'b1;
    r = 4'b0001;
    drive_model();
    run(8);

    tick();
    r = 4'b1000;
    drive_model();
    run(7);

    tick();
    obs.delete();
    rec_en = 1;
    r = 4'b1111;
    drive_model();
    run(30);
    rec_en = 0;
    exp_ord[0] = 4'b0001;
    exp_ord[1] = 4'b0100;
    exp_ord[2] = 4'b0010;
    exp_ord[3] = 4'b1000;
    chk(obs.size() == 4, "contention_count", obs.size(), 4);
    for (int i = 0; i < 4 && i < obs.size(); i++)
      chk(obs[i] == exp_ord[i], "contention_order", int'(obs[i]), int'(exp_ord[i]));

    // FP1 request that drops two cycles after the grant
    tick();
    r = 4'b0010;
    drive_model();
    if (granted) drop_at[gbit] = cyc + 2;
    run(8);
    chk(perr == 1'b1, "perr_sticky", int'(perr), 1);

    tick();
    r = 4'b0001;
    drive_model();
    run(7);
    tick();
    r = 4'b0100;
    drive_model();
    run(1);
    tick();
    rst = 1'b0;
    apply_reset();
    drive_model();
    repeat (3) begin
      tick();
      r = 4'($urandom);
      drive_model();
    end
    tick();
    rst = 1'b1;
    obs.delete();
    rec_en = 1;
    r = 4'b0101;
    drive_model();
    run(14);
    rec_en = 0;
    chk(obs.size() == 2, "post_reset_count", obs.size(), 2);
    if (obs.size() == 2) begin
      chk(obs[0] == 4'b0001, "post_reset_first", int'(obs[0]), 1);
      chk(obs[1] == 4'b0100, "post_reset_second", int'(obs[1]), 4);
    end

    rand_en = 1;
    run(400);
    rand_en = 0;
    run(60);

    tick();
    sw1_req = 2'b01;
    sw15_req = 2'b01;
    c0 = cyc;
    drive_model();
    repeat (25) begin
      tick();
      if (cyc == c0 + 3) sw1_req = 2'b00;
      if (cyc == c0 + 17) sw15_req = 2'b00;
      drive_model();
    end
    chk(n1 == 1, "lat1_acks", n1, 1);
    chk(c1 == c0 + 3, "lat1_ack_cycle", c1, c0 + 3);
    chk(n15 == 1, "lat15_acks", n15, 1);
    chk(c15 == c0 + 17, "lat15_ack_cycle", c15, c0 + 17);

    run(3);
    chk(mem_q.size() == 0, "mem_left", mem_q.size(), 0);
    chk(ack_q.size() == 0, "ack_left", ack_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
